time_disp_formatter: RTL and testbench

- Sequential, parametrised successor to the 12-hour display decoder.
- Captures a binary time (hours, minutes, optional seconds) on a load handshake.
- Converts each field to BCD with an iterative shift-add-3 (double-dabble) engine, applies 12h/24h formatting, and blinks the field under edit.
- Outputs packed 4-bit digit codes that feed the existing per-digit seven-segment Displayer instances.

---
 rtl/time_disp_formatter_if.sv | 27 ++
 rtl/time_disp_formatter.sv | 196 +++++++++++++++++++
 tb/tb_time_disp_formatter.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/time_disp_formatter_if.sv
// Load/result bundle between a time source and time_disp_formatter.
// The digit bus width follows NUM_FIELDS: 4 bits per digit, 2 + 2*NUM_FIELDS digits.
interface time_disp_formatter_if #(
    parameter int NUM_FIELDS = 3
);
    localparam int D = 2 + 2 * NUM_FIELDS;

    logic           load;
    logic           mode24;
    logic [4:0]     hours;
    logic [5:0]     minutes;
    logic [5:0]     seconds;
    logic [1:0]     editField;
    logic           busy;
    logic           done;
    logic [4*D-1:0] digits;

    modport master (
        output load, mode24, hours, minutes, seconds, editField,
        input  busy, done, digits
    );

    modport slave (
        input  load, mode24, hours, minutes, seconds, editField,
        output busy, done, digits
    );
endinterface

// File: rtl/time_disp_formatter.sv
// Captures a binary time, converts it to BCD with a serial double-dabble engine,
// applies 12h/24h formatting and blinks the field under edit.
//
// state  | meaning
// IDLE   | waiting for load; store holds the last committed digits
// CONV   | one double-dabble shift per edge, 6 edges per field
// COMMIT | write digit store, pulse done, release busy
module time_disp_formatter #(
    parameter int NUM_FIELDS = 3,
    parameter int BLINK_DIV  = 25000000,
    parameter int LZ_BLANK   = 0
) (
    input  logic clk,
    input  logic reset_n,
    time_disp_formatter_if.slave bus
);
    localparam int D  = 2 + 2 * NUM_FIELDS;
    localparam int DW = 4 * D;
    localparam int BW = $clog2(BLINK_DIV);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
    localparam logic [1:0]    LAST_FLD   = 2'(NUM_FIELDS - 1);

    typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_t;

    state_t state, state_nxt;

    logic          accept, conv, commit, busy_c;
    logic          step_last, fld_last;
    logic [1:0]    fld;
    logic [2:0]    step;
    logic [5:0]    bin_sr;
    logic [7:0]    acc, acc_adj, acc_nxt;

    logic [4:0]    hr_sat, hr_cap;
    logic [5:0]    min_sat, sec_sat;
    logic          pm_cap;
    logic [5:0]    min_lat, sec_lat;
    logic          mode_lat, pm_lat;
    logic [7:0]    bcd_h, bcd_m, bcd_s;

    logic [3:0]    dg [8];
    logic [DW-1:0] store, store_nxt, disp_nxt, digits_q;
    logic          done_q;
    logic [BW-1:0] blink_cnt;
    logic          blink_ph;

    // state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.load) state_nxt = CONV;
            CONV:    if (step_last && fld_last) state_nxt = COMMIT;
            COMMIT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        accept = 1'b0;
        conv   = 1'b0;
        commit = 1'b0;
        busy_c = 1'b1;
        case (state)
            IDLE:    begin busy_c = 1'b0; accept = bus.load; end
            CONV:    conv   = 1'b1;
            COMMIT:  commit = 1'b1;
            default: busy_c = 1'b0;
        endcase
    end

    assign bus.busy   = busy_c;
    assign bus.done   = done_q;
    assign bus.digits = digits_q;

    // Saturation and 12h mapping happen before conversion so the engine sees final hours.
    always_comb begin
        hr_sat  = (bus.hours   > 5'd23) ? 5'd23 : bus.hours;
        min_sat = (bus.minutes > 6'd59) ? 6'd59 : bus.minutes;
        sec_sat = (bus.seconds > 6'd59) ? 6'd59 : bus.seconds;
        hr_cap  = hr_sat;
        pm_cap  = 1'b0;
        if (!bus.mode24) begin
            if (hr_sat == 5'd0) begin
                hr_cap = 5'd12;
            end else if (hr_sat >= 5'd12) begin
                pm_cap = 1'b1;
                if (hr_sat > 5'd12) hr_cap = hr_sat - 5'd12;
            end
        end
    end

    assign step_last = (step == 3'd5);
    assign fld_last  = (fld == LAST_FLD);

    always_comb begin
        acc_adj      = acc;
        if (acc[3:0] >= 4'd5) acc_adj[3:0] = acc[3:0] + 4'd3;
        if (acc[7:4] >= 4'd5) acc_adj[7:4] = acc[7:4] + 4'd3;
        acc_nxt      = 8'({acc_adj, bin_sr[5]});
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            min_lat  <= '0;
            sec_lat  <= '0;
            mode_lat <= 1'b0;
            pm_lat   <= 1'b0;
            bin_sr   <= '0;
            acc      <= '0;
            step     <= '0;
            fld      <= '0;
            bcd_h    <= '0;
            bcd_m    <= '0;
            bcd_s    <= '0;
        end else if (accept) begin
            min_lat  <= min_sat;
            sec_lat  <= sec_sat;
            mode_lat <= bus.mode24;
            pm_lat   <= pm_cap;
            bin_sr   <= {1'b0, hr_cap};
            acc      <= '0;
            step     <= '0;
            fld      <= '0;
        end else if (conv) begin
            if (step_last) begin
                case (fld)
                    2'd0:    bcd_h <= acc_nxt;
                    2'd1:    bcd_m <= acc_nxt;
                    default: bcd_s <= acc_nxt;
                endcase
                bin_sr <= (fld == 2'd0) ? min_lat : sec_lat;
                acc    <= '0;
                step   <= '0;
                fld    <= fld + 2'd1;
            end else begin
                acc    <= acc_nxt;
                bin_sr <= {bin_sr[4:0], 1'b0};
                step   <= step + 3'd1;
            end
        end
    end

    // Digits 0/1 carry the AM/PM suffix; 24h mode blanks them.
    always_comb begin
        dg[0] = mode_lat ? 4'd15 : (pm_lat ? 4'd13 : 4'd12);
        dg[1] = mode_lat ? 4'd15 : 4'd10;
        dg[2] = ((LZ_BLANK != 0) && !mode_lat && (bcd_h[7:4] == 4'd0)) ? 4'd15 : bcd_h[7:4];
        dg[3] = bcd_h[3:0];
        dg[4] = bcd_m[7:4];
        dg[5] = bcd_m[3:0];
        dg[6] = bcd_s[7:4];
        dg[7] = bcd_s[3:0];
        store_nxt = '1;
        for (int i = 0; i < D; i++) store_nxt[4*i +: 4] = dg[i];
    end

    // Digit i belongs to field i/2 (1 = hours); digits beyond D never exist, so
    // editField = 3 in hh:mm builds blanks nothing.
    always_comb begin
        disp_nxt = store;
        for (int i = 2; i < D; i++) begin
            if (blink_ph && (bus.editField == 2'(i / 2))) disp_nxt[4*i +: 4] = 4'd15;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            store    <= '1;
            digits_q <= '1;
            done_q   <= 1'b0;
        end else begin
            done_q   <= commit;
            digits_q <= disp_nxt;
            if (commit) store <= store_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            blink_cnt <= '0;
            blink_ph  <= 1'b0;
        end else if (blink_cnt == BLINK_LAST) begin
            blink_cnt <= '0;
            blink_ph  <= ~blink_ph;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_time_disp_formatter.sv
// Directed bench: two hh:mm:ss instances (LZ_BLANK 0/1) and one hh:mm instance share stimulus.
module tb_time_disp_formatter;
    logic clk;
    logic reset_n;

    logic       t_load, t_mode24;
    logic [4:0] t_hours;
    logic [5:0] t_min, t_sec;
    logic [1:0] t_edit;

    int checks = 0;
    int errors = 0;

    time_disp_formatter_if #(.NUM_FIELDS(3)) if0 ();
    time_disp_formatter_if #(.NUM_FIELDS(3)) if1 ();
    time_disp_formatter_if #(.NUM_FIELDS(2)) if2 ();

    assign if0.load = t_load;  assign if0.mode24 = t_mode24; assign if0.hours = t_hours;
    assign if0.minutes = t_min; assign if0.seconds = t_sec;  assign if0.editField = t_edit;
    assign if1.load = t_load;  assign if1.mode24 = t_mode24; assign if1.hours = t_hours;
    assign if1.minutes = t_min; assign if1.seconds = t_sec;  assign if1.editField = t_edit;
    assign if2.load = t_load;  assign if2.mode24 = t_mode24; assign if2.hours = t_hours;
    assign if2.minutes = t_min; assign if2.seconds = t_sec;  assign if2.editField = t_edit;

    time_disp_formatter #(.NUM_FIELDS(3), .BLINK_DIV(4), .LZ_BLANK(0)) dut0 (
        .clk(clk), .reset_n(reset_n), .bus(if0));
    time_disp_formatter #(.NUM_FIELDS(3), .BLINK_DIV(4), .LZ_BLANK(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .bus(if1));
    time_disp_formatter #(.NUM_FIELDS(2), .BLINK_DIV(4), .LZ_BLANK(0)) dut2 (
        .clk(clk), .reset_n(reset_n), .bus(if2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // d0 is the AM/PM digit and lands in the low nibble.
    function automatic logic [31:0] pk(input logic [3:0] d0, d1, d2, d3, d4, d5, d6, d7);
        return {d7, d6, d5, d4, d3, d2, d1, d0};
    endfunction

    task automatic test_reset();
        reset_n  = 1'b0;
        t_load   = 1'b0;
        t_mode24 = 1'b0;
        t_hours  = '0;
        t_min    = '0;
        t_sec    = '0;
        t_edit   = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (if0.digits !== 32'hFFFF_FFFF || if2.digits !== 24'hFF_FFFF) begin
            errors++;
            $display("FAIL reset_digits: got %h/%h expected ffffffff/ffffff", if0.digits, if2.digits);
        end
        checks++;
        if ({if0.busy, if0.done} !== 2'b00) begin
            errors++;
            $display("FAIL reset_busy_done: got %b expected 00", {if0.busy, if0.done});
        end
        reset_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            checks++;
            if ({if0.digits, if0.busy, if0.done} !== {32'hFFFF_FFFF, 2'b00}) begin
                errors++;
                $display("FAIL idle_hold cycle %0d: got %h %b%b expected ffffffff 00",
                         c, if0.digits, if0.busy, if0.done);
            end
        end
    endtask

    // Pulses load, watches 26 cycles from the accept edge, then checks digits.
    task automatic run_conv(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s,
                            input logic md, input logic [31:0] e0, input logic [31:0] e1,
                            input string nm);
        int nb0, nd0, nb2, nd2, both;
        logic [23:0] e2;
        e2 = e0[23:0];
        nb0 = 0; nd0 = 0; nb2 = 0; nd2 = 0; both = 0;
        t_hours = h; t_min = m; t_sec = s; t_mode24 = md;
        @(negedge clk);
        t_load = 1'b1;
        @(negedge clk);
        t_load = 1'b0;
        for (int c = 0; c < 26; c++) begin
            if (c > 0) @(negedge clk);
            if (if0.busy) nb0++;
            if (if0.done) nd0++;
            if (if2.busy) nb2++;
            if (if2.done) nd2++;
            if (if0.busy && if0.done) both++;
        end
        checks++;
        if (nb0 !== 19 || nd0 !== 1) begin
            errors++;
            $display("FAIL %s timing3: got busy=%0d done=%0d expected busy=19 done=1", nm, nb0, nd0);
        end
        checks++;
        if (nb2 !== 13 || nd2 !== 1) begin
            errors++;
            $display("FAIL %s timing2: got busy=%0d done=%0d expected busy=13 done=1", nm, nb2, nd2);
        end
        checks++;
        if (both !== 0) begin
            errors++;
            $display("FAIL %s busy_and_done: got %0d overlapping cycles expected 0", nm, both);
        end
        checks++;
        if (if0.digits !== e0) begin
            errors++;
            $display("FAIL %s digits: got %h expected %h", nm, if0.digits, e0);
        end
        checks++;
        if (if1.digits !== e1) begin
            errors++;
            $display("FAIL %s digits_lz: got %h expected %h", nm, if1.digits, e1);
        end
        checks++;
        if (if2.digits !== e2) begin
            errors++;
            $display("FAIL %s digits_hhmm: got %h expected %h", nm, if2.digits, e2);
        end
    endtask

    task automatic test_basic();
        run_conv(5'd0, 6'd5, 6'd59, 1'b0, pk(12,10,1,2,0,5,5,9), pk(12,10,1,2,0,5,5,9), "midnight_12h");
    endtask

    task automatic test_modes();
        run_conv(5'd13, 6'd45, 6'd0, 1'b1, pk(15,15,1,3,4,5,0,0), pk(15,15,1,3,4,5,0,0), "13h_24h");
        run_conv(5'd13, 6'd45, 6'd0, 1'b0, pk(13,10,0,1,4,5,0,0), pk(13,10,15,1,4,5,0,0), "13h_12h");
    endtask

    task automatic test_saturation();
        run_conv(5'd30, 6'd61, 6'd63, 1'b0, pk(13,10,1,1,5,9,5,9), pk(13,10,1,1,5,9,5,9), "saturate");
    endtask

    task automatic test_hour_map();
        run_conv(5'd12, 6'd0, 6'd0, 1'b0, pk(13,10,1,2,0,0,0,0), pk(13,10,1,2,0,0,0,0), "noon_12h");
        run_conv(5'd5, 6'd9, 6'd30, 1'b1, pk(15,15,0,5,0,9,3,0), pk(15,15,0,5,0,9,3,0), "5h_24h");
        run_conv(5'd5, 6'd9, 6'd30, 1'b0, pk(12,10,0,5,0,9,3,0), pk(12,10,15,5,0,9,3,0), "5h_12h");
        run_conv(5'd23, 6'd59, 6'd59, 1'b1, pk(15,15,2,3,5,9,5,9), pk(15,15,2,3,5,9,5,9), "23h_24h");
    endtask

    task automatic test_load_ignored();
        int nb0, nd0, nd2;
        logic [31:0] e0;
        logic [23:0] e2;
        e0 = pk(15,15,0,9,0,7,0,3);
        e2 = e0[23:0];
        nb0 = 0; nd0 = 0; nd2 = 0;
        t_hours = 5'd9; t_min = 6'd7; t_sec = 6'd3; t_mode24 = 1'b1;
        @(negedge clk);
        t_load = 1'b1;
        @(negedge clk);
        t_load = 1'b0;
        t_hours = 5'd21; t_min = 6'd44; t_sec = 6'd11; t_mode24 = 1'b0;
        if (if0.busy) nb0++;
        for (int c = 1; c < 26; c++) begin
            t_load = (c == 3 || c == 10);
            @(negedge clk);
            if (if0.busy) nb0++;
            if (if0.done) nd0++;
            if (if2.done) nd2++;
        end
        t_load = 1'b0;
        checks++;
        if (nb0 !== 19 || nd0 !== 1 || nd2 !== 1) begin
            errors++;
            $display("FAIL busy_load_ignored: got busy=%0d done=%0d done2=%0d expected 19 1 1", nb0, nd0, nd2);
        end
        checks++;
        if (if0.digits !== e0 || if2.digits !== e2) begin
            errors++;
            $display("FAIL busy_load_data: got %h/%h expected %h/%h", if0.digits, if2.digits, e0, e2);
        end
    endtask

    task automatic test_reset_abort();
        int nd;
        nd = 0;
        t_hours = 5'd22; t_min = 6'd22; t_sec = 6'd22; t_mode24 = 1'b1;
        @(negedge clk);
        t_load = 1'b1;
        @(negedge clk);
        t_load = 1'b0;
        repeat (8) @(negedge clk);
        reset_n = 1'b0;
        #1;
        checks++;
        if ({if0.digits, if0.busy, if0.done} !== {32'hFFFF_FFFF, 2'b00}) begin
            errors++;
            $display("FAIL abort_async: got %h %b%b expected ffffffff 00", if0.digits, if0.busy, if0.done);
        end
        @(negedge clk);
        reset_n = 1'b1;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (if0.done || if0.busy) nd++;
        end
        checks++;
        if (nd !== 0) begin
            errors++;
            $display("FAIL abort_no_done: got %0d busy/done cycles expected 0", nd);
        end
        checks++;
        if (if0.digits !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL abort_store: got %h expected ffffffff", if0.digits);
        end
    endtask

    task automatic test_blink();
        logic [31:0] e;
        logic        mb [16];
        int          nblank, bad;
        e = pk(15,15,1,2,3,4,5,6);
        run_conv(5'd12, 6'd34, 6'd56, 1'b1, e, e, "blink_setup");
        t_edit = 2'd2;
        @(negedge clk);
        nblank = 0; bad = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            mb[i] = (if0.digits[23:16] === 8'hFF);
            if (mb[i]) nblank++;
            if ({if0.digits[31:24], if0.digits[15:0]} !== {e[31:24], e[15:0]}) bad++;
            if (!mb[i] && if0.digits[23:16] !== 8'h43) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL blink_steady: got %0d bad samples expected 0", bad);
        end
        checks++;
        if (nblank !== 8) begin
            errors++;
            $display("FAIL blink_duty: got %0d blank samples of 16 expected 8", nblank);
        end
        bad = 0;
        for (int i = 0; i < 12; i++) if (mb[i] == mb[i+4]) bad++;
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL blink_period: got %0d non-toggling pairs expected 0", bad);
        end
        t_edit = 2'd0;
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (if0.digits !== e) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL blink_off: got %0d blanked samples expected 0", bad);
        end
        t_edit = 2'd3;
        @(negedge clk);
        nblank = 0; bad = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (if2.digits !== e[23:0]) bad++;
            if (if0.digits[31:24] === 8'hFF) nblank++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL blink_sec_hhmm: got %0d blanked samples expected 0", bad);
        end
        checks++;
        if (nblank !== 4) begin
            errors++;
            $display("FAIL blink_sec_duty: got %0d blank samples of 8 expected 4", nblank);
        end
        t_edit = 2'd0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_modes();
        test_saturation();
        test_hour_map();
        test_load_ignored();
        test_reset_abort();
        test_blink();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
